// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit and its ALU.
// Latency: n/a (constants, types and encodings only).
// Backpressure: n/a.
// Contents: ALU opcodes, FSM state encoding, opcode/funct values, mux select codes,
// and the instruction class produced by the decoder.
package mc_pkg;

  // ALU opcodes; the ALU decodes exactly these values.
  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_ADDU = 4'b0001;
  localparam logic [3:0] ALUC_SUB  = 4'b0010;
  localparam logic [3:0] ALUC_SUBU = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_SLT  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1001;
  localparam logic [3:0] ALUC_SLL  = 4'b1010;
  localparam logic [3:0] ALUC_SRL  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_LUI  = 4'b1101;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // pc_src codes.
  localparam logic [1:0] PC_SEQ  = 2'd0;  // pc+4
  localparam logic [1:0] PC_BR   = 2'd1;  // pc+4+(simm<<2)
  localparam logic [1:0] PC_JUMP = 2'd2;  // {pc[31:28],instr[25:0],2'b00}
  localparam logic [1:0] PC_RS   = 2'd3;  // rs

  // rf_waddr_sel codes.
  localparam logic [1:0] WA_RD = 2'd0;
  localparam logic [1:0] WA_RT = 2'd1;
  localparam logic [1:0] WA_RA = 2'd2;

  // rf_wdata_sel codes.
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // What the FSM needs to know about the instruction in IR.
  typedef enum logic [3:0] {
    C_NOP  = 4'd0,  // unknown opcode/funct, executed as a no-op
    C_RALU = 4'd1,
    C_IALU = 4'd2,
    C_LW   = 4'd3,
    C_SW   = 4'd4,
    C_BEQ  = 4'd5,
    C_BNE  = 4'd6,
    C_J    = 4'd7,
    C_JAL  = 4'd8,
    C_JR   = 4'd9
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: maps the IR word to an instruction class and ALU controls.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows instr.
// Ports: instr (in, 32) -> iclass, aluc, alu_a_sel, alu_b_sel, ext_sign,
//        rf_waddr_sel, ovf_chk (1 for add/addi/sub, whose overflow suppresses writeback).
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic [3:0]  aluc,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        ext_sign,
  output logic [1:0]  rf_waddr_sel,
  output logic        ovf_chk
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // Register numbers, shamt and immediates go straight to the datapath.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    iclass       = C_NOP;
    aluc         = ALUC_ADDU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    ext_sign     = 1'b0;
    rf_waddr_sel = WA_RD;
    ovf_chk      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = C_RALU;
        case (funct)
          FN_ADD:  begin aluc = ALUC_ADD; ovf_chk = 1'b1; end
          FN_ADDU: aluc = ALUC_ADDU;
          FN_SUB:  begin aluc = ALUC_SUB; ovf_chk = 1'b1; end
          FN_SUBU: aluc = ALUC_SUBU;
          FN_AND:  aluc = ALUC_AND;
          FN_OR:   aluc = ALUC_OR;
          FN_XOR:  aluc = ALUC_XOR;
          FN_NOR:  aluc = ALUC_NOR;
          FN_SLT:  aluc = ALUC_SLT;
          FN_SLTU: aluc = ALUC_SLTU;
          // Constant shifts take the amount from shamt; the ALU shifts b by a.
          FN_SLL:  begin aluc = ALUC_SLL; alu_a_sel = 1'b1; end
          FN_SRL:  begin aluc = ALUC_SRL; alu_a_sel = 1'b1; end
          FN_SRA:  begin aluc = ALUC_SRA; alu_a_sel = 1'b1; end
          FN_SLLV: aluc = ALUC_SLL;
          FN_SRLV: aluc = ALUC_SRL;
          FN_SRAV: aluc = ALUC_SRA;
          FN_JR:   iclass = C_JR;
          default: iclass = C_NOP;
        endcase
      end
      OP_J:   iclass = C_J;
      OP_JAL: begin iclass = C_JAL; rf_waddr_sel = WA_RA; end
      OP_BEQ: begin iclass = C_BEQ; aluc = ALUC_SUBU; end
      OP_BNE: begin iclass = C_BNE; aluc = ALUC_SUBU; end
      OP_ADDI: begin
        iclass = C_IALU; aluc = ALUC_ADD; alu_b_sel = 1'b1; ext_sign = 1'b1;
        rf_waddr_sel = WA_RT; ovf_chk = 1'b1;
      end
      OP_ADDIU: begin
        iclass = C_IALU; aluc = ALUC_ADDU; alu_b_sel = 1'b1; ext_sign = 1'b1;
        rf_waddr_sel = WA_RT;
      end
      OP_SLTI: begin
        iclass = C_IALU; aluc = ALUC_SLT; alu_b_sel = 1'b1; ext_sign = 1'b1;
        rf_waddr_sel = WA_RT;
      end
      OP_SLTIU: begin
        iclass = C_IALU; aluc = ALUC_SLTU; alu_b_sel = 1'b1; ext_sign = 1'b1;
        rf_waddr_sel = WA_RT;
      end
      OP_ANDI: begin
        iclass = C_IALU; aluc = ALUC_AND; alu_b_sel = 1'b1; rf_waddr_sel = WA_RT;
      end
      OP_ORI: begin
        iclass = C_IALU; aluc = ALUC_OR; alu_b_sel = 1'b1; rf_waddr_sel = WA_RT;
      end
      OP_XORI: begin
        iclass = C_IALU; aluc = ALUC_XOR; alu_b_sel = 1'b1; rf_waddr_sel = WA_RT;
      end
      OP_LUI: begin
        iclass = C_IALU; aluc = ALUC_LUI; alu_b_sel = 1'b1; rf_waddr_sel = WA_RT;
      end
      OP_LW: begin
        iclass = C_LW; aluc = ALUC_ADDU; alu_b_sel = 1'b1; ext_sign = 1'b1;
        rf_waddr_sel = WA_RT;
      end
      OP_SW: begin
        iclass = C_SW; aluc = ALUC_ADDU; alu_b_sel = 1'b1; ext_sign = 1'b1;
        rf_waddr_sel = WA_RT;
      end
      default: iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the 31-instruction MIPS core.
// Latency: outputs combinational from state+IR; 2 (j/jal/jr/nop), 3 (branch), 4 (ALU, sw), 5 (lw) cycles.
// Backpressure: FETCH holds until imem_ready, MEM holds (enables asserted) until dmem_ready.
// Ports: clk, rst_n (sync, active-low); instr (IR word), imem_ready, dmem_ready,
//        alu_zero, alu_overflow in; aluc, operand/extend selects, ir_we, pc_we, pc_src,
//        rf_we, rf_waddr_sel, rf_wdata_sel, dmem_re, dmem_we, state (debug) out.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter state_t RESET_STATE  = S_FETCH,
  parameter bit     OVF_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic [3:0]  aluc,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        ext_sign,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  rf_waddr_sel,
  output logic [1:0]  rf_wdata_sel,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic [2:0]  state
);

  state_t     cur, nxt;
  iclass_t    d_class;
  logic [3:0] d_aluc;
  logic       d_a_sel, d_b_sel, d_ext_sign, d_ovf_chk;
  logic [1:0] d_waddr_sel;

  mc_decode u_decode (
    .instr        (instr),
    .iclass       (d_class),
    .aluc         (d_aluc),
    .alu_a_sel    (d_a_sel),
    .alu_b_sel    (d_b_sel),
    .ext_sign     (d_ext_sign),
    .rf_waddr_sel (d_waddr_sel),
    .ovf_chk      (d_ovf_chk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= RESET_STATE;
    else        cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt          = cur;
    aluc         = ALUC_ADDU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    ext_sign     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SEQ;
    rf_we        = 1'b0;
    rf_waddr_sel = WA_RD;
    rf_wdata_sel = WD_ALU;
    dmem_re      = 1'b0;
    dmem_we      = 1'b0;

    // ALU controls are driven from EXEC onward and held through MEM/WB so the
    // ALU result (address or writeback value) stays stable.
    if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
      aluc      = d_aluc;
      alu_a_sel = d_a_sel;
      alu_b_sel = d_b_sel;
      ext_sign  = d_ext_sign;
    end

    case (cur)
      S_FETCH: begin
        ir_we = imem_ready;
        pc_we = imem_ready;
        if (imem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        nxt = S_FETCH;
        case (d_class)
          C_J: begin
            pc_we  = 1'b1;
            pc_src = PC_JUMP;
          end
          C_JAL: begin
            pc_we        = 1'b1;
            pc_src       = PC_JUMP;
            rf_we        = 1'b1;
            rf_waddr_sel = WA_RA;
            rf_wdata_sel = WD_PC4;
          end
          C_JR: begin
            pc_we  = 1'b1;
            pc_src = PC_RS;
          end
          C_NOP:   nxt = S_FETCH;
          default: nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (d_class)
          C_RALU, C_IALU: nxt = S_WB;
          C_LW, C_SW:     nxt = S_MEM;
          C_BEQ: begin
            pc_we  = alu_zero;
            pc_src = PC_BR;
            nxt    = S_FETCH;
          end
          C_BNE: begin
            pc_we  = !alu_zero;
            pc_src = PC_BR;
            nxt    = S_FETCH;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_re = (d_class == C_LW);
        dmem_we = (d_class == C_SW);
        if (dmem_ready) nxt = (d_class == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we        = !(OVF_SUPPRESS && d_ovf_chk && alu_overflow);
        rf_waddr_sel = d_waddr_sel;
        rf_wdata_sel = (d_class == C_LW) ? WD_MEM : WD_ALU;
        nxt          = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    // Reset overrides everything so an abandoned instruction makes no writes.
    if (!rst_n) begin
      aluc         = ALUC_ADDU;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      ext_sign     = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_SEQ;
      rf_we        = 1'b0;
      rf_waddr_sel = WA_RD;
      rf_wdata_sel = WD_ALU;
      dmem_re      = 1'b0;
      dmem_we      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle output vectors against hand-computed values.
// Latency: n/a.
// Backpressure: exercises imem_ready and dmem_ready wait states.
module tb_mc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, alu_zero, alu_overflow;
  logic [3:0]  aluc;
  logic        alu_a_sel, alu_b_sel, ext_sign, ir_we, pc_we, rf_we, dmem_re, dmem_we;
  logic [1:0]  pc_src, rf_waddr_sel, rf_wdata_sel;
  logic [2:0]  state;

  mc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .aluc         (aluc),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .ext_sign     (ext_sign),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .rf_we        (rf_we),
    .rf_waddr_sel (rf_waddr_sel),
    .rf_wdata_sel (rf_wdata_sel),
    .dmem_re      (dmem_re),
    .dmem_we      (dmem_we),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All observable outputs of one cycle, in a fixed field order.
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] aluc;
    logic       a, b, e, ir, pc;
    logic [1:0] ps;
    logic       rf;
    logic [1:0] wa, wd;
    logic       re, we;
  } outs_t;

  typedef struct {
    logic        rst_n;
    logic [31:0] instr;
    logic        imr, dmr, z, ov;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;  // add  $3,$1,$2
  localparam logic [31:0] I_ADDI = 32'h2025_FFFF;  // addi $5,$1,-1
  localparam logic [31:0] I_ORI  = 32'h3425_8000;  // ori  $5,$1,0x8000
  localparam logic [31:0] I_SLL  = 32'h0003_1100;  // sll  $2,$3,4
  localparam logic [31:0] I_LUI  = 32'h3C04_1234;  // lui  $4,0x1234
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;  // beq  $1,$2,+3
  localparam logic [31:0] I_BNE  = 32'h1422_0003;  // bne  $1,$2,+3
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;  // jal
  localparam logic [31:0] I_JR   = 32'h03E0_0008;  // jr   $31
  localparam logic [31:0] I_SW   = 32'hAE08_0004;  // sw   $8,4($16)
  localparam logic [31:0] I_LW   = 32'h8E08_0004;  // lw   $8,4($16)
  localparam logic [31:0] I_BADF = 32'h0000_0001;  // R-type, unknown funct
  localparam logic [31:0] I_BADO = 32'hFC00_0000;  // unknown opcode

  outs_t act;
  assign act = {state, aluc, alu_a_sel, alu_b_sel, ext_sign, ir_we, pc_we, pc_src,
                rf_we, rf_waddr_sel, rf_wdata_sel, dmem_re, dmem_we};

  int   errors = 0;
  int   checks = 0;
  vec_t vt[$];

  function automatic outs_t eo(input int st, input int al, input int a, input int b,
                               input int e, input int ir, input int pc, input int ps,
                               input int rf, input int wa, input int wd, input int re,
                               input int we);
    outs_t o;
    o.st = 3'(st); o.aluc = 4'(al); o.a = 1'(a); o.b = 1'(b); o.e = 1'(e);
    o.ir = 1'(ir); o.pc = 1'(pc); o.ps = 2'(ps); o.rf = 1'(rf);
    o.wa = 2'(wa); o.wd = 2'(wd); o.re = 1'(re); o.we = 1'(we);
    return o;
  endfunction

  // FETCH with imem_ready=1, and DECODE of an instruction that goes on to EXEC.
  function automatic outs_t fe();
    return eo(0, 4'b0001, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic outs_t de();
    return eo(1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  // Reset-forced outputs in a given state.
  function automatic outs_t rs(input int st);
    return eo(st, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic pv(input logic [31:0] i, input logic imr, input logic dmr,
                    input logic z, input logic ov, input outs_t e);
    vec_t v;
    v.rst_n = 1'b1; v.instr = i; v.imr = imr; v.dmr = dmr; v.z = z; v.ov = ov; v.exp = e;
    vt.push_back(v);
  endtask

  // Field order of got/expected: st aluc a b ext ir pc psrc rf wa wd re we.
  task automatic chk(input string tag, input outs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b_%b_%b%b%b_%b%b_%b_%b_%b_%b_%b%b expected %b_%b_%b%b%b_%b%b_%b_%b_%b_%b_%b%b",
               tag, act.st, act.aluc, act.a, act.b, act.e, act.ir, act.pc, act.ps, act.rf,
               act.wa, act.wd, act.re, act.we, e.st, e.aluc, e.a, e.b, e.e, e.ir, e.pc,
               e.ps, e.rf, e.wa, e.wd, e.re, e.we);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // add, no overflow then overflow in WB
    pv(I_ADD, 1, 1, 0, 0, fe());
    pv(I_ADD, 1, 1, 0, 0, de());
    pv(I_ADD, 1, 1, 0, 0, eo(2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pv(I_ADD, 1, 1, 0, 0, eo(4, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    pv(I_ADD, 1, 1, 0, 1, fe());
    pv(I_ADD, 1, 1, 0, 1, de());
    pv(I_ADD, 1, 1, 0, 1, eo(2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pv(I_ADD, 1, 1, 0, 1, eo(4, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // addi: sign-extended imm, overflow suppresses the write
    pv(I_ADDI, 1, 1, 0, 1, fe());
    pv(I_ADDI, 1, 1, 0, 1, de());
    pv(I_ADDI, 1, 1, 0, 1, eo(2, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    pv(I_ADDI, 1, 1, 0, 1, eo(4, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    // ori: zero-extended, overflow flag ignored
    pv(I_ORI, 1, 1, 0, 1, fe());
    pv(I_ORI, 1, 1, 0, 1, de());
    pv(I_ORI, 1, 1, 0, 1, eo(2, 4'b0101, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pv(I_ORI, 1, 1, 0, 1, eo(4, 4'b0101, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // sll: a=shamt
    pv(I_SLL, 1, 1, 0, 0, fe());
    pv(I_SLL, 1, 1, 0, 0, de());
    pv(I_SLL, 1, 1, 0, 0, eo(2, 4'b1010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pv(I_SLL, 1, 1, 0, 0, eo(4, 4'b1010, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // lui
    pv(I_LUI, 1, 1, 0, 0, fe());
    pv(I_LUI, 1, 1, 0, 0, de());
    pv(I_LUI, 1, 1, 0, 0, eo(2, 4'b1101, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pv(I_LUI, 1, 1, 0, 0, eo(4, 4'b1101, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // beq taken / not taken, bne with zero / non-zero
    pv(I_BEQ, 1, 1, 1, 0, fe());
    pv(I_BEQ, 1, 1, 1, 0, de());
    pv(I_BEQ, 1, 1, 1, 0, eo(2, 4'b0011, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    pv(I_BEQ, 1, 1, 0, 0, fe());
    pv(I_BEQ, 1, 1, 0, 0, de());
    pv(I_BEQ, 1, 1, 0, 0, eo(2, 4'b0011, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    pv(I_BNE, 1, 1, 1, 0, fe());
    pv(I_BNE, 1, 1, 1, 0, de());
    pv(I_BNE, 1, 1, 1, 0, eo(2, 4'b0011, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    pv(I_BNE, 1, 1, 0, 0, fe());
    pv(I_BNE, 1, 1, 0, 0, de());
    pv(I_BNE, 1, 1, 0, 0, eo(2, 4'b0011, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // jal, jr
    pv(I_JAL, 1, 1, 0, 0, fe());
    pv(I_JAL, 1, 1, 0, 0, eo(1, 4'b0001, 0, 0, 0, 0, 1, 2, 1, 2, 2, 0, 0));
    pv(I_JR, 1, 1, 0, 0, fe());
    pv(I_JR, 1, 1, 0, 0, eo(1, 4'b0001, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
    // sw, zero-wait
    pv(I_SW, 1, 1, 0, 0, fe());
    pv(I_SW, 1, 1, 0, 0, de());
    pv(I_SW, 1, 1, 0, 0, eo(2, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    pv(I_SW, 1, 1, 0, 0, eo(3, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    // unknown funct, then unknown opcode behind a 2-cycle imem stall
    pv(I_BADF, 1, 1, 0, 0, fe());
    pv(I_BADF, 1, 1, 0, 0, de());
    pv(I_BADO, 0, 1, 0, 0, rs(0));
    pv(I_BADO, 0, 1, 0, 0, rs(0));
    pv(I_BADO, 1, 1, 0, 0, fe());
    pv(I_BADO, 1, 1, 0, 0, de());

    // Power-on reset.
    rst_n = 1'b0; instr = I_BEQ; imem_ready = 1'b1; dmem_ready = 1'b1;
    alu_zero = 1'b1; alu_overflow = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk); chk("por", rs(0));
    next_cycle();
    // Run a taken beq to EXEC, then reset it mid-EXEC for two cycles.
    rst_n = 1'b1;
    @(negedge clk); chk("rst_fetch", fe());
    next_cycle();
    @(negedge clk); chk("rst_decode", de());
    next_cycle();
    @(negedge clk); chk("rst_exec_live", eo(2, 4'b0011, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1 chk("rst_exec_forced", rs(2));
    next_cycle();
    @(negedge clk); chk("rst_hold", rs(0));
    next_cycle();

    // Table: first row releases reset and must see FETCH.
    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rst_n; instr = vt[i].instr; imem_ready = vt[i].imr;
      dmem_ready = vt[i].dmr; alu_zero = vt[i].z; alu_overflow = vt[i].ov;
      @(negedge clk);
      chk($sformatf("vec%0d", i), vt[i].exp);
      next_cycle();
    end

    // lw with dmem_ready low for 3 cycles: MEM held 4 cycles with dmem_re up.
    instr = I_LW; imem_ready = 1'b1; dmem_ready = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    @(negedge clk); chk("lw_fetch", fe());
    next_cycle();
    @(negedge clk); chk("lw_decode", de());
    next_cycle();
    @(negedge clk); chk("lw_exec", eo(2, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      dmem_ready = (k == 3);
      @(negedge clk);
      chk($sformatf("lw_mem%0d", k), eo(3, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      next_cycle();
    end
    @(negedge clk); chk("lw_wb", eo(4, 4'b0001, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    next_cycle();
    @(negedge clk); chk("lw_back_fetch", fe());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the 31-instruction MIPS core.
- Sits directly upstream of the ALU. It drives the ALU's 4-bit aluc opcode and operand selects, and consumes the ALU zero/overflow flags.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and produces all PC, IR, register-file and data-memory enables.
- Waits on ready handshakes from instruction and data memory.

Parameters:
- RESET_STATE, S_FETCH: state entered on reset.
- OVF_SUPPRESS, 1: when 1, add/addi/sub results that overflow are not written back.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- instr  in  32  instruction word. Valid on imem_rdata during FETCH; IR contents thereafter (IR is external, loaded by ir_we).
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- aluc  out  4  ALU opcode: ADD=0000, ADDU=0001, SUB=0010, SUBU=0011, AND=0100, OR=0101, XOR=0110, NOR=0111, SLT=1000, SLTU=1001, SLL=1010, SRL=1011, SRA=1100, LUI=1101.
- alu_a_sel  out  1  0=rs, 1=zero-extended shamt.
- alu_b_sel  out  1  0=rt, 1=extended imm16.
- ext_sign  out  1  1=sign-extend imm16, 0=zero-extend.
- ir_we  out  1  load IR.
- pc_we  out  1  update PC.
- pc_src  out  2  0=pc+4, 1=pc+4+(simm<<2), 2={pc[31:28],instr[25:0],2'b00}, 3=rs.
- rf_we  out  1  register-file write.
- rf_waddr_sel  out  2  0=rd, 1=rt, 2=$31.
- rf_wdata_sel  out  2  0=ALU result, 1=dmem read data, 2=pc+4.
- dmem_re  out  1  data memory read.
- dmem_we  out  1  data memory write.
- state  out  3  current state, for debug.

Behaviour:
- Reset:
  - While rst_n=0 at a clk edge, state goes to S_FETCH.
  - During any cycle with rst_n=0, all enables (ir_we, pc_we, rf_we, dmem_re, dmem_we) are forced 0.
  - Selects reset to 0 and aluc to ADDU.
  - Reset mid-instruction abandons it with no partial writes after that edge.
- Outputs are combinational from state and the decoded IR. The FSM is the only state.
- FETCH: ir_we=imem_ready, pc_we=imem_ready, pc_src=0. Stay until imem_ready, then go to DECODE.
- DECODE:
  - j: pc_we=1, pc_src=2. Go to FETCH.
  - jal: as j, plus rf_we=1, waddr=$31, wdata=pc+4. Go to FETCH.
  - jr: pc_we=1, pc_src=3. Go to FETCH.
  - Unknown opcode/funct: no enables; go to FETCH (NOP).
  - All others go to EXEC.
- EXEC:
  - R-type ALU ops map by funct: add/addu/sub/subu/and/or/xor/nor/slt/sltu, a=rs, b=rt.
  - sll/srl/sra: a=shamt, b=rt. sllv/srlv/srav: a=rs, b=rt. The ALU shifts b by a.
  - addi/addiu/slti/sltiu use sign-extension. andi/ori/xori use zero-extension. lui uses aluc=LUI with b=imm.
  - lw/sw: aluc=ADDU, b=sign-extended imm. Go to MEM.
  - beq/bne: aluc=SUBU, b=rt. pc_we=alu_zero (beq) or !alu_zero (bne), pc_src=1. Go to FETCH.
  - ALU ops go to WB.
- MEM: dmem_re=1 (lw) or dmem_we=1 (sw), held until dmem_ready. On dmem_ready: lw goes to WB, sw goes to FETCH. Enables stay asserted for every wait cycle.
- WB:
  - rf_we=1. rf_waddr_sel: rd for R-type, rt for I-type and lw. rf_wdata_sel: 1 for lw, else 0.
  - aluc and selects are held from EXEC so the result is stable.
  - If OVF_SUPPRESS=1 and the op is add/addi/sub and alu_overflow=1, rf_we=0.
  - Go to FETCH.
- Writes to $0 are not blocked here; the register file ignores them.
- Cycle counts with zero-wait memories: R/I-type 4, lw 5, sw 4, branch 3, j/jal/jr 2, NOP 2.

Decomposition:
- Shared package mc_pkg:
  - aluc localparams (shared with the ALU).
  - State encodings S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4.
  - Opcode/funct constants.
  - pc_src, rf_waddr_sel and rf_wdata_sel codes.
- One natural sub-module: mc_decode. Purely combinational: instr to instruction class, aluc, alu_a_sel, alu_b_sel, ext_sign, rf_waddr_sel.
- The FSM and enable generation stay in mc_ctrl.

Test Plan:
- Reset with rst_n=0 for 2 cycles mid-EXEC, then release -> state=0 and all enables 0 during reset; first cycle after release is FETCH.
- add $3,$1,$2 (0x00221820), ready always 1 -> states 0,1,2,4; WB rf_we=1, waddr_sel=0, aluc=0000. With alu_overflow=1 in WB -> rf_we=0.
- lw $8,4($16) (0x8E080004), dmem_ready low for 3 cycles -> MEM held 4 cycles with dmem_re=1 throughout; WB rf_wdata_sel=1, waddr_sel=1, aluc=0001, ext_sign=1.
- beq $1,$2,+3 (0x10220003) -> alu_zero=1 gives pc_we=1, pc_src=1; alu_zero=0 gives pc_we=0. Both return to FETCH after 3 cycles. bne (0x14220003) gives the inverse.
- jal 0x0C000010 -> DECODE pc_we=1, pc_src=2, rf_we=1, waddr_sel=2, wdata_sel=2; sll $2,$3,4 (0x00031100) -> EXEC alu_a_sel=1, aluc=1010.
- Unknown opcode 0xFC000000 -> FETCH then DECODE, no enables, back to FETCH. imem_ready low for 2 cycles -> FETCH held, ir_we=0.
